// File: rtl/uart_pkg.sv
// Shared register map, bit positions and FSM state types for the
// memory-mapped UART and its FIFOs.
package uart_pkg;

  localparam int ADDR_CTRL   = 0;
  localparam int ADDR_DATA   = 1;
  localparam int ADDR_STATUS = 2;
  localparam int ADDR_DIV    = 3;

  localparam int CTRL_TX_EN     = 0;
  localparam int CTRL_RX_EN     = 1;
  localparam int CTRL_IRQ_RX    = 2;
  localparam int CTRL_IRQ_TXE   = 3;
  localparam int CTRL_TX_FLUSH  = 4;
  localparam int CTRL_RX_FLUSH  = 5;

  localparam int ST_TX_EMPTY     = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_RX_EMPTY     = 2;
  localparam int ST_RX_FULL      = 3;
  localparam int ST_OVERRUN      = 4;
  localparam int ST_FRAME_ERR    = 5;
  localparam int ST_BUSY         = 6;
  localparam int ST_RX_COUNT_LSB = 8;
  localparam int ST_TX_COUNT_LSB = 16;

  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Divisors below MIN_DIV leave too few clocks to find the bit centre.
  function automatic logic [15:0] clamp_div(input logic [15:0] value);
    return (value < MIN_DIV) ? MIN_DIV : value;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with flush; a pop on empty is ignored, and a push on full
// is accepted only when a pop frees a slot in the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_fifo_io.sv
// Memory-mapped 8N1 UART: CPU register file, TX/RX byte FIFOs, programmable
// baud divisor, sticky error flags and a registered level interrupt.
module uart_fifo_io
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 10416,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  input  logic              write_enable,
  input  logic              read_enable,
  output logic              tx,
  input  logic              rx,
  output logic              busy,
  output logic              irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic sel_ctrl, sel_data, sel_status, sel_div;
  logic wr_ctrl, wr_data, wr_status, wr_div, rd_data;
  logic tx_flush, rx_flush;
  logic unused_data_in;

  logic [3:0]  ctrl_q, ctrl_d;
  logic [15:0] div_q, div_d;
  logic        overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic [31:0] data_out_q, data_out_d, rd_value, status_word;
  logic        irq_q, irq_d;

  logic [7:0]  tx_head, rx_head;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic        tx_pop, rx_push;

  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_q, tx_d, tx_last, tx_start_ok, tx_shifting;

  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_last, rx_stop_sample, rx_set_overrun, rx_set_frame_err;

  assign sel_ctrl   = (addr == ADDR_W'(ADDR_CTRL));
  assign sel_data   = (addr == ADDR_W'(ADDR_DATA));
  assign sel_status = (addr == ADDR_W'(ADDR_STATUS));
  assign sel_div    = (addr == ADDR_W'(ADDR_DIV));
  assign wr_ctrl    = write_enable & sel_ctrl;
  assign wr_data    = write_enable & sel_data;
  assign wr_status  = write_enable & sel_status;
  assign wr_div     = write_enable & sel_div;
  assign rd_data    = read_enable & sel_data;
  assign tx_flush   = wr_ctrl & data_in[CTRL_TX_FLUSH];
  assign rx_flush   = wr_ctrl & data_in[CTRL_RX_FLUSH];
  assign unused_data_in = ^data_in[31:16];

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .flush(tx_flush),
    .push(wr_data), .push_data(data_in[7:0]), .pop(tx_pop),
    .head(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .flush(rx_flush),
    .push(rx_push), .push_data(rx_shift_q), .pop(rd_data),
    .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  always_comb begin
    ctrl_d      = ctrl_q;
    div_d       = div_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (wr_ctrl) ctrl_d = data_in[3:0];
    if (wr_div)  div_d  = clamp_div(data_in[15:0]);
    if (wr_status && data_in[ST_OVERRUN])   overrun_d   = 1'b0;
    if (wr_status && data_in[ST_FRAME_ERR]) frame_err_d = 1'b0;
    if (rx_set_overrun)   overrun_d   = 1'b1;
    if (rx_set_frame_err) frame_err_d = 1'b1;
  end

  always_comb begin
    status_word = '0;
    status_word[ST_TX_EMPTY]  = tx_empty;
    status_word[ST_TX_FULL]   = tx_full;
    status_word[ST_RX_EMPTY]  = rx_empty;
    status_word[ST_RX_FULL]   = rx_full;
    status_word[ST_OVERRUN]   = overrun_q;
    status_word[ST_FRAME_ERR] = frame_err_q;
    status_word[ST_BUSY]      = busy;
    status_word[ST_RX_COUNT_LSB +: 8] = 8'(rx_count);
    status_word[ST_TX_COUNT_LSB +: 8] = 8'(tx_count);
  end

  always_comb begin
    rd_value = '0;
    if (sel_ctrl)        rd_value = {28'b0, ctrl_q};
    else if (sel_data)   rd_value = rx_empty ? 32'b0 : {24'b0, rx_head};
    else if (sel_status) rd_value = status_word;
    else if (sel_div)    rd_value = {16'b0, div_q};
    data_out_d = read_enable ? rd_value : data_out_q;
    irq_d = (ctrl_q[CTRL_IRQ_RX] & ~rx_empty)
          | (ctrl_q[CTRL_IRQ_TXE] & tx_empty & ~tx_shifting)
          | overrun_q | frame_err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q      <= '0;
      div_q       <= 16'(CLK_DIV);
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      data_out_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      div_q       <= div_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      data_out_q  <= data_out_d;
      irq_q       <= irq_d;
    end
  end

  assign data_out    = data_out_q;
  assign irq         = irq_q;
  assign tx          = tx_q;
  assign tx_shifting = (tx_state_q != TX_IDLE);
  assign busy        = tx_shifting | ~tx_empty;

  // Divisor is latched per frame so a DIV write never disturbs a frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= 16'(CLK_DIV);
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  assign tx_last     = (tx_cnt_q == tx_div_q - 1'b1);
  assign tx_start_ok = ctrl_q[CTRL_TX_EN] & ~tx_empty & ~tx_flush;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (tx_start_ok) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_div_d   = div_q;
          tx_state_d = TX_START;
        end
      end
      TX_START: if (tx_last) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_last) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        tx_bit_d   = tx_bit_q + 1'b1;
        if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_last) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_IDLE;
        if (tx_start_ok) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_div_d   = div_q;
          tx_state_d = TX_START;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (tx_state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= 16'(CLK_DIV);
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  assign rx_last = (rx_cnt_q == rx_div_q - 1'b1);

  // START samples half a bit in; every later sample is a full bit apart.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (ctrl_q[CTRL_RX_EN] && rx_prev_q && !rx_sync_q) begin
          rx_div_d   = div_q;
          rx_state_d = RX_START;
        end
      end
      RX_START: if (rx_cnt_q == (rx_div_q >> 1)) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_last) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_last) begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_stop_sample   = (rx_state_q == RX_STOP) & rx_last;
    rx_push          = rx_stop_sample & rx_sync_q & ~rx_full;
    rx_set_overrun   = rx_stop_sample & rx_sync_q & rx_full;
    rx_set_frame_err = rx_stop_sample & ~rx_sync_q;
  end

endmodule

// File: tb/tb_uart_fifo_io.sv
// Directed bench for uart_fifo_io: register vector table plus hand-written
// serial sequences (TX burst, loopback, overrun, frame error, glitch, full FIFO).
module tb_uart_fifo_io;

  localparam int DEPTH    = 4;
  localparam int BIT_CLKS = 16;
  localparam int NV       = 12;

  typedef struct {
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_val;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  addr;
  logic [31:0] data_in, data_out;
  logic        write_enable, read_enable;
  logic        tx, rx, busy, irq;
  logic        loop_en, rx_drv;
  int          total = 0;
  int          bad = 0;

  assign rx = loop_en ? tx : rx_drv;
  always #5 clk = ~clk;

  uart_fifo_io #(.CLK_DIV(10416), .FIFO_DEPTH(DEPTH), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in),
    .data_out(data_out), .write_enable(write_enable), .read_enable(read_enable),
    .tx(tx), .rx(rx), .busy(busy), .irq(irq)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic we, input logic re,
                                input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    write_enable = we;
    read_enable  = re;
    addr         = a;
    data_in      = d;
    @(negedge clk);
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
    apply_stimulus(1'b1, 1'b0, a, d);
  endtask

  task automatic reg_check(input string name, input logic [3:0] a, input logic [31:0] expected);
    apply_stimulus(1'b0, 1'b1, a, 32'h0);
    check_output(name, data_out, expected);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx_byte(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = frame[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs [NV];
    logic [19:0] tx_expect;
    logic [7:0]  b;
    bit          seen;
    int          n;

    vecs[0]  = '{1'b0, 1'b1, 4'd2, 32'h0,    1'b1, 32'h0000_0005};
    vecs[1]  = '{1'b0, 1'b1, 4'd0, 32'h0,    1'b1, 32'h0000_0000};
    vecs[2]  = '{1'b0, 1'b1, 4'd3, 32'h0,    1'b1, 32'd10416};
    vecs[3]  = '{1'b0, 1'b1, 4'd7, 32'h0,    1'b1, 32'h0000_0000};
    vecs[4]  = '{1'b1, 1'b0, 4'd3, 32'h2,    1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 4'd3, 32'h0,    1'b1, 32'h0000_0004};
    vecs[6]  = '{1'b1, 1'b0, 4'd0, 32'h3F,   1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 4'd0, 32'h0,    1'b1, 32'h0000_000F};
    vecs[8]  = '{1'b1, 1'b0, 4'd0, 32'h0,    1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 4'd3, 32'h10,   1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 4'd9, 32'hFFFF, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 4'd3, 32'h0,    1'b1, 32'h0000_0010};

    write_enable = 1'b0;
    read_enable  = 1'b0;
    addr         = '0;
    data_in      = '0;
    loop_en      = 1'b0;
    rx_drv       = 1'b1;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a start bit must raise tx immediately.
    reg_write(4'd3, 32'd16);
    reg_write(4'd1, 32'hF0);
    reg_check("div_pre_reset", 4'd3, 32'd16);
    reg_write(4'd0, 32'h1);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (tx === 1'b0) seen = 1;
    end
    check_output("mid_frame_start_bit", {31'b0, tx}, 32'h0);
    idle(4);
    #2 rst_n = 1'b0;
    #1;
    check_output("reset_tx_high", {31'b0, tx}, 32'h1);
    check_output("reset_busy", {31'b0, busy}, 32'h0);
    check_output("reset_irq", {31'b0, irq}, 32'h0);
    check_output("reset_data_out", data_out, 32'h0);
    idle(2);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply_stimulus(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].chk) check_output($sformatf("vec%0d", i), data_out, vecs[i].exp_val);
    end

    // Two queued bytes go out as contiguous frames, LSB first.
    reg_write(4'd1, 32'h55);
    reg_write(4'd1, 32'hA3);
    reg_check("tx_queued_status", 4'd2, 32'h0002_0044);
    tx_expect = {1'b1, 8'hA3, 1'b0, 1'b1, 8'h55, 1'b0};
    reg_write(4'd0, 32'h1);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (tx === 1'b0) seen = 1;
      else @(negedge clk);
    end
    check_output("tx_burst_start", {31'b0, seen}, 32'h1);
    n = 0;
    while (seen && busy && n < 400) begin
      @(negedge clk);
      n++;
      if (n >= 8 && (n - 8) % BIT_CLKS == 0 && (n - 8) / BIT_CLKS < 20)
        check_output($sformatf("tx_bit%0d", (n - 8) / BIT_CLKS), {31'b0, tx},
                     {31'b0, tx_expect[(n - 8) / BIT_CLKS]});
    end
    check_output("tx_burst_len", n, 32'd320);
    reg_check("tx_done_status", 4'd2, 32'h0000_0005);

    loop_en = 1'b1;
    reg_write(4'd0, 32'h3);
    reg_write(4'd1, 32'h3C);
    idle(220);
    reg_check("loop_status", 4'd2, 32'h0000_0101);
    reg_check("loop_data", 4'd1, 32'h0000_003C);
    idle(3);
    check_output("data_out_hold", data_out, 32'h0000_003C);
    reg_check("loop_rx_empty", 4'd2, 32'h0000_0005);

    loop_en = 1'b0;
    reg_write(4'd0, 32'h6);
    for (int i = 0; i < 5; i++) begin
      b = 8'(8'h11 * (i + 1));
      send_rx_byte(b, 1'b1);
    end
    idle(4);
    check_output("irq_rx", {31'b0, irq}, 32'h1);
    reg_check("overrun_status", 4'd2, 32'h0000_0419);
    reg_write(4'd2, 32'h10);
    reg_check("overrun_clear", 4'd2, 32'h0000_0409);
    for (int i = 0; i < 4; i++) begin
      b = 8'(8'h11 * (i + 1));
      reg_check($sformatf("overrun_byte%0d", i), 4'd1, {24'b0, b});
    end
    idle(2);
    check_output("irq_clear", {31'b0, irq}, 32'h0);
    reg_check("drained_status", 4'd2, 32'h0000_0005);

    send_rx_byte(8'h5A, 1'b0);
    idle(4);
    reg_check("frame_err_status", 4'd2, 32'h0000_0025);
    reg_write(4'd2, 32'h20);
    reg_check("frame_err_clear", 4'd2, 32'h0000_0005);

    rx_drv = 1'b0;
    idle(BIT_CLKS / 4);
    rx_drv = 1'b1;
    idle(40);
    reg_check("glitch_status", 4'd2, 32'h0000_0005);

    reg_write(4'd0, 32'h0);
    for (int i = 0; i < 5; i++) reg_write(4'd1, 32'hA0 + i);
    reg_check("tx_full_status", 4'd2, 32'h0004_0046);
    apply_stimulus(1'b1, 1'b1, 4'd1, 32'h99);
    check_output("rx_empty_pop", data_out, 32'h0);
    reg_check("tx_full_after_rw", 4'd2, 32'h0004_0046);
    reg_write(4'd0, 32'h10);
    reg_check("tx_flush", 4'd2, 32'h0000_0005);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
